// File: rtl/data_receiver_pkg.sv
// Shared constants and state encoding for the framed serial link receiver.
package data_receiver_pkg;

    localparam int unsigned RX_WIDTH       = 64;
    localparam int unsigned RX_TIMEOUT     = 1024;
    localparam int unsigned RX_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_DRAIN   = 2'd2
    } rx_state_e;

endpackage

// File: rtl/data_receiver_synchronizer.sv
// Multi-flop synchronizer for one asynchronous line input; clears to 0 on reset.
module data_receiver_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d};
        end
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/data_receiver.sv
// Deserializes MSB-first frames from the serial link into WIDTH-bit words,
// flagging short, overrun and stalled frames with a frame_error strobe.
module data_receiver
    import data_receiver_pkg::*;
#(
    parameter int unsigned WIDTH       = RX_WIDTH,
    parameter int unsigned SYNC_STAGES = RX_SYNC_STAGES,
    parameter int unsigned TIMEOUT     = RX_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_transmission,
    input  logic             rx_clock,
    input  logic             rx_data,
    output logic [WIDTH-1:0] out_data,
    output logic             valid,
    output logic             frame_error,
    output logic             busy
);

    localparam int unsigned CNT_W  = $clog2(WIDTH + 2);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT);
    localparam int unsigned WARM_W = $clog2(SYNC_STAGES + 2);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_OVER  = CNT_W'(WIDTH + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

    logic s_transmission;
    logic s_clock;
    logic s_data;

    data_receiver_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_transmission (
        .clk (clk),
        .rst (rst),
        .d   (rx_transmission),
        .q   (s_transmission)
    );

    data_receiver_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_clock (
        .clk (clk),
        .rst (rst),
        .d   (rx_clock),
        .q   (s_clock)
    );

    data_receiver_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clk (clk),
        .rst (rst),
        .d   (rx_data),
        .q   (s_data)
    );

    rx_state_e         state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic              trans_dly_q;
    logic              clock_dly_q;
    logic [WIDTH-1:0]  out_data_d;
    logic              valid_d;
    logic              frame_error_d;
    logic              busy_d;

    logic trans_rise;
    logic trans_fall;
    logic clock_rise;

    assign trans_rise = s_transmission & ~trans_dly_q;
    assign trans_fall = ~s_transmission & trans_dly_q;
    assign clock_rise = s_clock & ~clock_dly_q;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            warm_q      <= '0;
            trans_dly_q <= 1'b0;
            clock_dly_q <= 1'b0;
            out_data    <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            warm_q      <= warm_d;
            trans_dly_q <= s_transmission;
            clock_dly_q <= s_clock;
            out_data    <= out_data_d;
            valid       <= valid_d;
            frame_error <= frame_error_d;
            busy        <= busy_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        out_data_d    = out_data;
        valid_d       = 1'b0;
        frame_error_d = 1'b0;
        warm_d        = (warm_q == WARM_DONE) ? warm_q : warm_q + WARM_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                // Until the synchronizers have flushed after reset, a high line
                // means we joined mid-frame and must wait it out.
                if (warm_q != WARM_DONE) begin
                    if (s_transmission) begin
                        state_d = ST_DRAIN;
                    end
                end else if (trans_rise) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = ST_RECEIVE;
                end
            end
            ST_RECEIVE: begin
                if (clock_rise) begin
                    shift_d = {shift_q[WIDTH-2:0], s_data};
                    cnt_d   = (cnt_q == CNT_OVER) ? cnt_q : cnt_q + CNT_W'(1);
                    tmo_d   = '0;
                end
                // A bit arriving with the frame close counts toward the check.
                if (trans_fall) begin
                    if (cnt_d == CNT_FULL) begin
                        out_data_d = shift_d;
                        valid_d    = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (!clock_rise) begin
                    if (tmo_q == TMO_LAST) begin
                        frame_error_d = 1'b1;
                        state_d       = ST_DRAIN;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!s_transmission) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_data_receiver.sv
// Randomized self-checking bench for data_receiver against a frame-level model.
module tb_data_receiver;

    localparam int unsigned W  = 64;
    localparam int unsigned SS = 2;
    localparam int unsigned TO = 1024;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rx_transmission = 1'b0;
    logic         rx_clock = 1'b0;
    logic         rx_data = 1'b0;
    logic [W-1:0] out_data;
    logic         valid;
    logic         frame_error;
    logic         busy;

    data_receiver #(.WIDTH(W), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_transmission (rx_transmission),
        .rx_clock        (rx_clock),
        .rx_data         (rx_data),
        .out_data        (out_data),
        .valid           (valid),
        .frame_error     (frame_error),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;
    int valid_cyc = 0;
    int err_cyc = 0;

    logic [W-1:0] exp_word = '0;

    always @(posedge clk) cyc++;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            valid_cyc = cyc;
        end
        if (frame_error) begin
            n_err++;
            err_cyc = cyc;
        end
        if (valid && frame_error) n_both++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_data = b;
        tick($urandom_range(3, 5));
        rx_clock = 1'b1;
        tick($urandom_range(3, 5));
        rx_clock = 1'b0;
    endtask

    // Sends nbits MSB first (bits[nbits-1] first) and checks the frame outcome.
    task automatic frame(input int nbits, input logic [127:0] bits, input bit same_cycle);
        int v0;
        int e0;
        int fall_cyc;
        v0 = n_valid;
        e0 = n_err;
        fall_cyc = 0;
        rx_transmission = 1'b1;
        tick($urandom_range(4, 8));
        chk("busy_in_frame", 64'(busy), 64'd1);
        for (int i = 0; i < nbits; i++) begin
            if (same_cycle && i == nbits - 1) begin
                rx_data = bits[nbits-1-i];
                tick(4);
                rx_clock = 1'b1;
                rx_transmission = 1'b0;
                fall_cyc = cyc + 1;
                tick(4);
                rx_clock = 1'b0;
            end else begin
                send_bit(bits[nbits-1-i]);
            end
        end
        if (!same_cycle) begin
            tick($urandom_range(0, 3));
            rx_transmission = 1'b0;
            fall_cyc = cyc + 1;
        end
        tick(8);
        if (nbits == W) begin
            exp_word = bits[W-1:0];
            chk("valid_count", 64'(n_valid - v0), 64'd1);
            chk("error_count", 64'(n_err - e0), 64'd0);
            chk("valid_latency", 64'(valid_cyc - fall_cyc), 64'(SS));
        end else begin
            chk("valid_count", 64'(n_valid - v0), 64'd0);
            chk("error_count", 64'(n_err - e0), 64'd1);
        end
        chk("out_data", out_data, exp_word);
        chk("busy_after", 64'(busy), 64'd0);
    endtask

    initial begin
        int v0;
        int e0;
        int rise_cyc;
        int dt;
        logic [127:0] r;

        tick(2);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_error", 64'(frame_error), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        tick(6);

        frame(64, 128'hDEADBEEF01234567, 1'b0);
        r = {$urandom, $urandom, $urandom, $urandom};
        frame(63, r, 1'b0);
        r = {$urandom, $urandom, $urandom, $urandom};
        frame(65, r, 1'b0);
        frame(64, 128'h1, 1'b0);

        // Stalled serial clock inside a frame.
        v0 = n_valid;
        e0 = n_err;
        rx_transmission = 1'b1;
        tick(6);
        for (int i = 0; i < 9; i++) send_bit(1'($urandom));
        rx_data = 1'b1;
        tick(4);
        rx_clock = 1'b1;
        rise_cyc = cyc + 1;
        tick(4);
        rx_clock = 1'b0;
        tick(TO + 80);
        chk("timeout_error_count", 64'(n_err - e0), 64'd1);
        dt = err_cyc - rise_cyc;
        chk("timeout_window", 64'(dt >= int'(TO) && dt <= int'(TO + SS + 2)), 64'd1);
        chk("timeout_drain_busy", 64'(busy), 64'd1);
        rx_transmission = 1'b0;
        tick(8);
        chk("timeout_exit_error_count", 64'(n_err - e0), 64'd1);
        chk("timeout_exit_valid_count", 64'(n_valid - v0), 64'd0);
        chk("timeout_exit_busy", 64'(busy), 64'd0);
        chk("timeout_out_data", out_data, exp_word);

        // Asynchronous reset in the middle of a frame.
        rx_transmission = 1'b1;
        tick(6);
        for (int i = 0; i < 30; i++) send_bit(1'($urandom));
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_out_data", out_data, 64'd0);
        chk("mid_rst_valid", 64'(valid), 64'd0);
        chk("mid_rst_error", 64'(frame_error), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        exp_word = '0;
        tick(2);
        rst = 1'b1;
        v0 = n_valid;
        e0 = n_err;
        tick(5);
        chk("post_rst_drain_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 34; i++) send_bit(1'($urandom));
        tick(3);
        rx_transmission = 1'b0;
        tick(8);
        chk("post_rst_valid_count", 64'(n_valid - v0), 64'd0);
        chk("post_rst_error_count", 64'(n_err - e0), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        r = {$urandom, $urandom, $urandom, $urandom};
        frame(64, r, 1'b0);

        // Last bit and frame close land in the same synchronized cycle.
        frame(64, 128'hA5C3_0F1E_7788_9911, 1'b1);

        for (int k = 0; k < 12; k++) begin
            int len;
            r = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 5))
                0:       len = 63;
                1:       len = 65;
                2:       len = int'($urandom_range(1, 62));
                default: len = 64;
            endcase
            frame(len, r, 1'($urandom_range(0, 3) == 0 && len == 64));
        end

        chk("pulse_exclusive", 64'(n_both), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
